ssd_scan_engine: RTL and testbench

//   Time-multiplexed N-digit 7-segment display driver with built-in refresh counter and hex decoder.

---
 rtl/ssd_scan_engine_if.sv | 25 ++
 rtl/ssd_scan_engine.sv | 172 +++++++++++++++++
 tb/tb_ssd_scan_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_engine_if.sv
// ssd_scan_engine_if: display-data and scan-output bundle for ssd_scan_engine.
// The master drives digit data and per-digit controls; the slave (the scan engine)
// drives the active-low digit enables, segments and the frame_start pulse.
interface ssd_scan_engine_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   ssd_ctl;
  logic [7:0]              ssd_segs;
  logic                    frame_start;

  modport master (
    output digits_in, dp_in, blank_mask, lz_en, blink_mask,
    input  ssd_ctl, ssd_segs, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_mask, lz_en, blink_mask,
    output ssd_ctl, ssd_segs, frame_start
  );
endinterface

// File: rtl/ssd_scan_engine.sv
// ssd_scan_engine: time-multiplexed N-digit 7-segment driver with refresh counter,
// hex decoder, per-frame input snapshot, leading-zero blanking, blank and dp control.
// Optional blinking is compiled in when the macro SSD_BLINK_EN is defined.
// All outputs are registered; inputs reach them only through flops.
module ssd_scan_engine #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_TICKS = 50000,
  parameter int BLINK_TICKS   = 2**24
) (
  input logic              clk,
  input logic              rst,
  ssd_scan_engine_if.slave bus
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_W = $clog2(REFRESH_TICKS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_TICKS - 1);

  // Scan state and frame snapshot
  logic [TICK_W-1:0]       tick_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    first_q;
  logic [4*NUM_DIGITS-1:0] digits_snap_q;
  logic [NUM_DIGITS-1:0]   dp_snap_q;
  logic [NUM_DIGITS-1:0]   blank_snap_q;
  logic                    lz_snap_q;

  // Registered outputs
  logic [NUM_DIGITS-1:0]   ctl_q, ctl_d;
  logic [7:0]              segs_q, segs_d;
  logic                    frame_start_q;

  // Combinational helpers
  logic                    tick_wrap;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] view_digits;
  logic [NUM_DIGITS-1:0]   view_dp;
  logic [NUM_DIGITS-1:0]   view_blank;
  logic                    view_lz;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    all_zero;
  logic [3:0]              cur_nibble;
  logic                    blink_dark;
  logic                    dark;

`ifdef SSD_BLINK_EN
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  logic [BLINK_W-1:0]    blink_cnt_q;
  logic                  phase_q;
  logic [NUM_DIGITS-1:0] blink_snap_q;
  logic [NUM_DIGITS-1:0] view_blink;
`endif

  // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  // Next-state decode: wrap events, digit darkness and the next output pattern
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    tick_wrap   = (tick_q == TICK_LAST);
    // The first cycle after reset loads the snapshot even though idx is already 0.
    load        = first_q || (tick_wrap && (idx_q == IDX_LAST));
    // On that first cycle the display shows the live inputs it is capturing, so
    // digit 0 never flashes the cleared snapshot for one cycle.
    view_digits = first_q ? bus.digits_in  : digits_snap_q;
    view_dp     = first_q ? bus.dp_in      : dp_snap_q;
    view_blank  = first_q ? bus.blank_mask : blank_snap_q;
    view_lz     = first_q ? bus.lz_en      : lz_snap_q;
    lz_dark     = '0;
    all_zero    = 1'b1;
    // A digit is LZ-blanked when it and every more significant nibble are zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (view_digits[4*i +: 4] == 4'h0);
      lz_dark[i] = view_lz && (i > 0) && all_zero;
    end
`ifdef SSD_BLINK_EN
    view_blink  = first_q ? bus.blink_mask : blink_snap_q;
    blink_dark  = phase_q && view_blink[idx_q];
`else
    blink_dark  = 1'b0;
`endif
    cur_nibble  = view_digits[4*int'(idx_q) +: 4];
    dark        = view_blank[idx_q] || lz_dark[idx_q] || blink_dark;
    ctl_d       = dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    segs_d      = dark ? 8'hFF : {hex_to_seg(cur_nibble), ~view_dp[idx_q]};
  end

  // Refresh tick, digit index and once-per-frame input snapshot
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      tick_q        <= '0;
      idx_q         <= '0;
      first_q       <= 1'b1;
      digits_snap_q <= '0;
      dp_snap_q     <= '0;
      blank_snap_q  <= '0;
      lz_snap_q     <= 1'b0;
    end else begin
      first_q <= 1'b0;
      tick_q  <= tick_wrap ? '0 : tick_q + 1'b1;
      if (tick_wrap) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (load) begin
        digits_snap_q <= bus.digits_in;
        dp_snap_q     <= bus.dp_in;
        blank_snap_q  <= bus.blank_mask;
        lz_snap_q     <= bus.lz_en;
      end
    end
  end

  // Output registers: dark during reset, otherwise one cycle behind idx
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q         <= '1;
      segs_q        <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      ctl_q         <= ctl_d;
      segs_q        <= segs_d;
      frame_start_q <= load;
    end
  end

`ifdef SSD_BLINK_EN
  // Free-running blink counter; phase 1 darkens digits flagged in the snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      blink_snap_q <= '0;
    end else begin
      blink_cnt_q <= (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        phase_q <= ~phase_q;
      end
      if (load) begin
        blink_snap_q <= bus.blink_mask;
      end
    end
  end
`endif

  assign bus.ssd_ctl     = ctl_q;
  assign bus.ssd_segs    = segs_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_engine.sv
// tb_ssd_scan_engine: directed self-checking bench for ssd_scan_engine with
// NUM_DIGITS=4, REFRESH_TICKS=4, BLINK_TICKS=16. Each digit is shown for 4 clocks,
// so one frame is 16 clocks. Outputs are sampled 1 time unit after each rising edge.
module tb_ssd_scan_engine;

  localparam int ND = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ssd_scan_engine_if #(.NUM_DIGITS(ND)) bus ();

  ssd_scan_engine #(
    .NUM_DIGITS   (ND),
    .REFRESH_TICKS(4),
    .BLINK_TICKS  (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low {a..g,dp} bytes with dp off (LSB = 1)
  localparam logic [7:0] S0 = 8'h03;
  localparam logic [7:0] S1 = 8'h9F;
  localparam logic [7:0] S2 = 8'h25;
  localparam logic [7:0] S3 = 8'h0D;
  localparam logic [7:0] S4 = 8'h99;
  localparam logic [7:0] S5 = 8'h49;
  localparam logic [7:0] SD = 8'hFF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one full frame. ec holds the expected ssd_ctl per digit ([3:0]=digit 0),
  // es the expected ssd_segs per digit ([7:0]=digit 0). frame_start is expected on
  // the last cycle (next wrap) and, for the frame right after reset, on the first.
  task automatic run_frame(input string name, input logic [15:0] ec, input logic [31:0] es,
                           input bit first, input int change_at, input logic [15:0] new_digits);
    for (int c = 0; c < 16; c++) begin
      int   k;
      logic exp_fs;
      step();
      k      = c / 4;
      exp_fs = (c == 15) || (first && (c == 0));
      checks++;
      if (bus.ssd_ctl !== ec[4*k +: 4]) begin
        errors++;
        $display("FAIL %s ctl c=%0d got %b exp %b", name, c, bus.ssd_ctl, ec[4*k +: 4]);
      end
      checks++;
      if (bus.ssd_segs !== es[8*k +: 8]) begin
        errors++;
        $display("FAIL %s segs c=%0d got %h exp %h", name, c, bus.ssd_segs, es[8*k +: 8]);
      end
      checks++;
      if (bus.frame_start !== exp_fs) begin
        errors++;
        $display("FAIL %s frame_start c=%0d got %b exp %b", name, c, bus.frame_start, exp_fs);
      end
      if (c == change_at) bus.digits_in = new_digits;
    end
  endtask

  // Advance until frame_start is seen, bounded to 40 cycles.
  task automatic wait_frame_start(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.frame_start !== 1'b1 && n < 40);
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_start wait got %b exp 1", name, bus.frame_start);
    end
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                            input logic lz, input logic [3:0] bk);
    bus.digits_in  = d;
    bus.dp_in      = dp;
    bus.blank_mask = bl;
    bus.lz_en      = lz;
    bus.blink_mask = bk;
  endtask

  task automatic test_reset();
    set_inputs(16'h1234, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.ssd_ctl !== 4'b1111) begin
      errors++;
      $display("FAIL reset ctl got %b exp 1111", bus.ssd_ctl);
    end
    checks++;
    if (bus.ssd_segs !== SD) begin
      errors++;
      $display("FAIL reset segs got %h exp ff", bus.ssd_segs);
    end
    checks++;
    if (bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset frame_start got %b exp 0", bus.frame_start);
    end
  endtask

  task automatic test_scan();
    run_frame("scan_1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {S1, S2, S3, S4}, 1'b1, -1, 16'h0);
  endtask

  task automatic test_lz_0050();
    set_inputs(16'h0050, 4'b0000, 4'b0000, 1'b1, 4'b0000);
    wait_frame_start("lz_0050");
    run_frame("lz_0050", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
              {SD, SD, S5, S0}, 1'b0, -1, 16'h0);
  endtask

  task automatic test_lz_0000();
    set_inputs(16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0000);
    wait_frame_start("lz_0000");
    run_frame("lz_0000", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
              {SD, SD, SD, S0}, 1'b0, -1, 16'h0);
  endtask

  task automatic test_dp_blank();
    set_inputs(16'h1234, 4'b0100, 4'b0001, 1'b0, 4'b0000);
    wait_frame_start("dp_blank");
    run_frame("dp_blank", {4'b0111, 4'b1011, 4'b1101, 4'b1111},
              {S1, S2 & 8'hFE, S3, SD}, 1'b0, -1, 16'h0);
  endtask

  task automatic test_tear_free();
    set_inputs(16'h1111, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    wait_frame_start("tear_free");
    // Change to 2222 while idx=2; the current frame must still show all '1'.
    run_frame("tear_old", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {S1, S1, S1, S1}, 1'b0, 9, 16'h2222);
    run_frame("tear_new", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {S2, S2, S2, S2}, 1'b0, -1, 16'h0);
  endtask

  task automatic test_reset_mid_frame();
    wait_frame_start("rst_mid");
    for (int i = 0; i < 13; i++) step();  // idx is now 3
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.ssd_ctl !== 4'b1111 || bus.ssd_segs !== SD || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid dark got ctl=%b segs=%h fs=%b exp 1111 ff 0",
               bus.ssd_ctl, bus.ssd_segs, bus.frame_start);
    end
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1110 || bus.ssd_segs !== S2 || bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid digit0 got ctl=%b segs=%h fs=%b exp 1110 25 1",
               bus.ssd_ctl, bus.ssd_segs, bus.frame_start);
    end
    // Tick restarted at 0: digit 0 holds for three more cycles, then digit 1.
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.ssd_ctl !== 4'b1110) begin
        errors++;
        $display("FAIL rst_mid hold%0d ctl got %b exp 1110", i, bus.ssd_ctl);
      end
    end
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1101) begin
      errors++;
      $display("FAIL rst_mid digit1 ctl got %b exp 1101", bus.ssd_ctl);
    end
  endtask

`ifdef SSD_BLINK_EN
  task automatic test_blink();
    set_inputs(16'h1234, 4'b0000, 4'b0000, 1'b0, 4'b1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_frame("blink_on0", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {S1, S2, S3, S4}, 1'b1, -1, 16'h0);
    run_frame("blink_off", {4'b1111, 4'b1011, 4'b1101, 4'b1110},
              {SD, S2, S3, S4}, 1'b0, -1, 16'h0);
    run_frame("blink_on1", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {S1, S2, S3, S4}, 1'b0, -1, 16'h0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_inputs(16'h0, 4'b0, 4'b0, 1'b0, 4'b0);
    test_reset();
    test_scan();
    test_lz_0050();
    test_lz_0000();
    test_dp_blank();
    test_tear_free();
    test_reset_mid_frame();
`ifdef SSD_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
